// File: rtl/minmax_level_monitor.sv
// Debounced hysteresis level monitor for the min/max averaging stage output word.
// Produces rise/fall pulses, a level flag, a saturating rise counter and the peak of the last high excursion.
module minmax_level_monitor #(
    parameter int MSB      = 31,
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid,
    input  logic [MSB:0]     in,
    input  logic [MSB:0]     hi_thr,
    input  logic [MSB:0]     lo_thr,
    output logic             level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] event_count,
    output logic [MSB:0]     peak
);

    localparam logic [1:0] ST_LOW  = 2'd0;
    localparam logic [1:0] ST_RISE = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_FALL = 2'd3;
    localparam logic [7:0] DEB_C   = 8'(DEBOUNCE);

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [MSB:0]     max_q, max_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [MSB:0]     peak_q, peak_d;

    logic             rise_ok_s;
    logic             fall_ok_s;
    logic [MSB:0]     max_upd_s;
    logic [7:0]       cnt_inc_s;
    logic             go_high_s;
    logic             go_low_s;

    assign rise_ok_s = (in >= hi_thr);
    assign fall_ok_s = (in <= lo_thr);
    assign max_upd_s = (in > max_q) ? in : max_q;
    assign cnt_inc_s = cnt_q + 8'd1;

    // Next-state: FSM advances only on valid samples; entry side effects applied after the case.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        level_d   = level_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        count_d   = count_q;
        peak_d    = peak_q;
        go_high_s = 1'b0;
        go_low_s  = 1'b0;
        if (valid) begin
            case (state_q)
                ST_LOW: begin
                    if (rise_ok_s) begin
                        max_d = in;
                        if (DEBOUNCE == 1) begin
                            go_high_s = 1'b1;
                        end else begin
                            state_d = ST_RISE;
                            cnt_d   = 8'd1;
                        end
                    end else begin
                        state_d = ST_LOW;
                    end
                end
                ST_RISE: begin
                    if (rise_ok_s) begin
                        max_d = max_upd_s;
                        if (cnt_inc_s >= DEB_C) begin
                            go_high_s = 1'b1;
                        end else begin
                            cnt_d = cnt_inc_s;
                        end
                    end else begin
                        state_d = ST_LOW;
                        cnt_d   = 8'd0;
                    end
                end
                ST_HIGH: begin
                    max_d = max_upd_s;
                    if (fall_ok_s) begin
                        if (DEBOUNCE == 1) begin
                            go_low_s = 1'b1;
                        end else begin
                            state_d = ST_FALL;
                            cnt_d   = 8'd1;
                        end
                    end else begin
                        state_d = ST_HIGH;
                    end
                end
                ST_FALL: begin
                    max_d = max_upd_s;
                    if (fall_ok_s) begin
                        if (cnt_inc_s >= DEB_C) begin
                            go_low_s = 1'b1;
                        end else begin
                            cnt_d = cnt_inc_s;
                        end
                    end else begin
                        state_d = ST_HIGH;
                        cnt_d   = 8'd0;
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = 8'd0;
                    max_d   = {(MSB+1){1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (go_high_s) begin
            state_d = ST_HIGH;
            cnt_d   = 8'd0;
            level_d = 1'b1;
            rise_d  = 1'b1;
            count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
        end else begin
            rise_d = 1'b0;
        end

        // The final max already includes the sample on the completing cycle.
        if (go_low_s) begin
            state_d = ST_LOW;
            cnt_d   = 8'd0;
            level_d = 1'b0;
            fall_d  = 1'b1;
            peak_d  = max_upd_s;
            max_d   = {(MSB+1){1'b0}};
        end else begin
            fall_d = 1'b0;
        end
    end

    // State and registered outputs; clear wins over any event completing this cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOW;
            cnt_q   <= 8'd0;
            max_q   <= {(MSB+1){1'b0}};
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            count_q <= {CNT_W{1'b0}};
            peak_q  <= {(MSB+1){1'b0}};
        end else if (clear) begin
            state_q <= ST_LOW;
            cnt_q   <= 8'd0;
            max_q   <= {(MSB+1){1'b0}};
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            count_q <= {CNT_W{1'b0}};
            peak_q  <= {(MSB+1){1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            count_q <= count_d;
            peak_q  <= peak_d;
        end
    end

    assign level       = level_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign event_count = count_q;
    assign peak        = peak_q;

endmodule
